pc_sequencer: RTL

Control block that drives the program counter's jump_en/jump_addr inputs each cycle. It decides sequential fetch, taken branch, subroutine call, return, stall or halt. It owns a small hardware return-address stack and a RUN/HALT/FAULT state machine. It sits between instruction decode and the program counter. The program counter's pc_out feeds back as pc_in.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/ret_stack.sv | 51 +++++
 rtl/pc_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the program-counter sequencer.
package cpu_pkg;

  // Sequencer operating state.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } seq_state_t;

  // Sticky fault cause reported while in FAULT.
  localparam logic [1:0] FAULT_NONE = 2'b00;
  localparam logic [1:0] FAULT_OVF  = 2'b01;
  localparam logic [1:0] FAULT_UNF  = 2'b10;

endpackage

// File: rtl/ret_stack.sv
// Hardware return-address LIFO: registered push/pop, combinational top of stack.
module ret_stack #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic [ADDR_W-1:0]              push_data,
  output logic [ADDR_W-1:0]              top,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(STACK_DEPTH):0]   depth
);

  localparam int PW = $clog2(STACK_DEPTH);
  localparam int DW = PW + 1;

  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [DW-1:0]     depth_reg;
  logic [PW-1:0]     wr_idx;
  logic [PW-1:0]     rd_idx;

  // The write slot is the current depth; the top entry sits one below it.
  assign wr_idx = depth_reg[PW-1:0];
  assign rd_idx = wr_idx - PW'(1);
  assign full   = (depth_reg == DW'(STACK_DEPTH));
  assign empty  = (depth_reg == '0);
  assign depth  = depth_reg;
  assign top    = mem[rd_idx];

  // Entry storage; contents survive reset, only the pointer is cleared.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

  // Depth pointer: guarded so an illegal push/pop never corrupts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth_reg <= '0;
    end else if (push && !full) begin
      depth_reg <= depth_reg + DW'(1);
    end else if (pop && !empty) begin
      depth_reg <= depth_reg - DW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC control: RUN/HALT/FAULT state machine plus a priority mux that
// drives the PC load port. Holding the PC is done by reloading pc_in.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_W-1:0]              pc_in,
  input  logic                           stall,
  input  logic                           branch_req,
  input  logic                           branch_cond,
  input  logic [ADDR_W-1:0]              branch_target,
  input  logic                           call_req,
  input  logic                           ret_req,
  input  logic                           halt_req,
  input  logic                           resume,
  output logic                           jump_en,
  output logic [ADDR_W-1:0]              jump_addr,
  output logic                           halted,
  output logic                           fault,
  output logic [1:0]                     fault_code,
  output logic [$clog2(STACK_DEPTH):0]   stack_depth
);

  seq_state_t        state_reg, state_next;
  logic [1:0]        fault_code_reg, fault_code_next;
  logic              push, pop;
  logic [ADDR_W-1:0] stack_top;
  logic              stack_full, stack_empty;
  logic [ADDR_W-1:0] ret_addr;

  // Return address wraps naturally at the address width.
  assign ret_addr = pc_in + ADDR_W'(1);

  ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (ret_addr),
    .top       (stack_top),
    .full      (stack_full),
    .empty     (stack_empty),
    .depth     (stack_depth)
  );

  // State and sticky fault cause.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= RUN;
      fault_code_reg <= FAULT_NONE;
    end else begin
      state_reg      <= state_next;
      fault_code_reg <= fault_code_next;
    end
  end

  // Priority decode: only the highest-priority request acts in RUN.
  always_comb begin
    state_next      = state_reg;
    fault_code_next = fault_code_reg;
    jump_en         = 1'b0;
    jump_addr       = '0;
    push            = 1'b0;
    pop             = 1'b0;
    if (!reset) begin
      case (state_reg)
        RUN: begin
          if (stall) begin
            jump_en   = 1'b1;
            jump_addr = pc_in;
          end else if (halt_req) begin
            jump_en    = 1'b1;
            jump_addr  = pc_in;
            state_next = HALT;
          end else if (ret_req) begin
            jump_en = 1'b1;
            if (stack_empty) begin
              jump_addr       = pc_in;
              state_next      = FAULT;
              fault_code_next = FAULT_UNF;
            end else begin
              jump_addr = stack_top;
              pop       = 1'b1;
            end
          end else if (call_req) begin
            jump_en = 1'b1;
            if (stack_full) begin
              jump_addr       = pc_in;
              state_next      = FAULT;
              fault_code_next = FAULT_OVF;
            end else begin
              jump_addr = branch_target;
              push      = 1'b1;
            end
          end else if (branch_req && branch_cond) begin
            jump_en   = 1'b1;
            jump_addr = branch_target;
          end
        end
        HALT: begin
          jump_en   = 1'b1;
          jump_addr = pc_in;
          if (resume) begin
            state_next = RUN;
          end
        end
        FAULT: begin
          jump_en   = 1'b1;
          jump_addr = pc_in;
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  assign halted     = (state_reg == HALT);
  assign fault      = (state_reg == FAULT);
  assign fault_code = fault_code_reg;

endmodule
